// File: rtl/ema_alu_pkg.sv
// Shared constants for the EMA filter arithmetic unit: operation codes and
// the width of the mode field carried alongside each beat.
package ema_alu_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] ALU_IDLE    = 3'd0;
    localparam logic [MODE_W-1:0] ALU_ADD     = 3'd1;
    localparam logic [MODE_W-1:0] ALU_MULT    = 3'd2;
    localparam logic [MODE_W-1:0] ALU_SUB     = 3'd3;
    localparam logic [MODE_W-1:0] ALU_MULQ    = 3'd4;
    localparam logic [MODE_W-1:0] ALU_MAC     = 3'd5;
    localparam logic [MODE_W-1:0] ALU_ACC_CLR = 3'd6;

endpackage

// File: rtl/ema_sat.sv
// Combinational signed saturator: clips a wide two's-complement value into
// the signed WOUT range and flags whether clipping happened.
module ema_sat #(
    parameter int WIN_FULL = 34,
    parameter int WOUT     = 32
) (
    input  logic signed [WIN_FULL-1:0] value,
    output logic signed [WOUT-1:0]     clipped,
    output logic                       sat
);

    generate
        if (WIN_FULL > WOUT) begin : g_clip
            localparam logic signed [WIN_FULL-1:0] MAX_VAL =
                {{(WIN_FULL-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
            localparam logic signed [WIN_FULL-1:0] MIN_VAL =
                {{(WIN_FULL-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

            // Compare against the output range limits and clip when outside
            always_comb begin
                clipped = value[WOUT-1:0];
                sat     = 1'b0;
                if (value > MAX_VAL) begin
                    clipped = MAX_VAL[WOUT-1:0];
                    sat     = 1'b1;
                end else if (value < MIN_VAL) begin
                    clipped = MIN_VAL[WOUT-1:0];
                    sat     = 1'b1;
                end
            end
        end else begin : g_pass
            // A value no wider than the output always fits, so sign-extend only
            assign clipped = WOUT'(value);
            assign sat     = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ema_alu_pipe.sv
// Two-stage registered arithmetic unit for the EMA filter datapath.
// Stage 1 captures the beat; stage 2 computes, saturates and registers the
// result together with the running MAC accumulator. A stalled output freezes
// both stages, so beats are never dropped or duplicated.
module ema_alu_pipe
    import ema_alu_pkg::*;
#(
    parameter int WIN   = 16,
    parameter int WCOEF = 17,
    parameter int WOUT  = 32,
    parameter int FRAC  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [MODE_W-1:0]        mode_i,
    input  logic signed [WIN-1:0]    op1_i,
    input  logic signed [WCOEF-1:0]  op2_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic signed [WOUT-1:0]   res_o,
    output logic                     sat_o
);

    // Operands need WIN+WCOEF+1 bits; one more bit above the larger of that
    // and WOUT leaves headroom for accumulator + product without wrapping.
    localparam int WFULL = WIN + WCOEF + 1;
    localparam int WCALC = ((WFULL > WOUT) ? WFULL : WOUT) + 1;

    localparam logic signed [WCALC-1:0] ROUND_HALF =
        {{(WCALC-1){1'b0}}, 1'b1} <<< (FRAC - 1);

    logic                     stall;
    logic                     s1_valid;
    logic [MODE_W-1:0]        s1_mode;
    logic signed [WIN-1:0]    s1_op1;
    logic signed [WCOEF-1:0]  s1_op2;
    logic signed [WOUT-1:0]   acc;

    logic signed [WCALC-1:0]  op1_x;
    logic signed [WCALC-1:0]  op2_x;
    logic signed [WCALC-1:0]  prod;
    logic signed [WCALC-1:0]  pre_sat;
    logic signed [WOUT-1:0]   res_clip;
    logic                     res_flag;

    assign stall   = valid_o && !ready_i;
    assign ready_o = !stall;

    // Stage 1: capture an accepted beat, or a bubble when nothing is offered
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= ALU_IDLE;
            s1_op1   <= '0;
            s1_op2   <= '0;
        end else if (!stall) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_mode <= mode_i;
                s1_op1  <= op1_i;
                s1_op2  <= op2_i;
            end
        end
    end

    assign op1_x = WCALC'(s1_op1);
    assign op2_x = WCALC'(s1_op2);
    assign prod  = op1_x * op2_x;

    // Full-precision result selection before saturation; MAC folds in the accumulator
    always_comb begin
        pre_sat = '0;
        case (s1_mode)
            ALU_ADD:  pre_sat = op1_x + op2_x;
            ALU_MULT: pre_sat = prod;
            ALU_SUB:  pre_sat = op1_x - op2_x;
            ALU_MULQ: pre_sat = (prod + ROUND_HALF) >>> FRAC;
            ALU_MAC:  pre_sat = WCALC'(acc) + prod;
            default:  pre_sat = '0;
        endcase
    end

    // The MAC result is the new accumulator, so one saturator serves both paths
    ema_sat #(
        .WIN_FULL (WCALC),
        .WOUT     (WOUT)
    ) u_res_sat (
        .value   (pre_sat),
        .clipped (res_clip),
        .sat     (res_flag)
    );

    // Stage 2: register result and flag, update the accumulator only when loading
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            res_o   <= '0;
            sat_o   <= 1'b0;
            acc     <= '0;
        end else if (!stall) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                res_o <= res_clip;
                sat_o <= res_flag;
                if (s1_mode == ALU_MAC) begin
                    acc <= res_clip;
                end else if (s1_mode == ALU_ACC_CLR) begin
                    acc <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ema_alu_pipe.sv
// Self-checking bench for ema_alu_pipe: directed cases with known answers,
// backpressure and mid-flight reset, then randomized traffic scored against
// an arithmetic reference model with a FIFO of expected results.
module tb_ema_alu_pipe;

    localparam int WIN   = 16;
    localparam int WCOEF = 17;
    localparam int WOUT  = 32;
    localparam int FRAC  = 16;

    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_ADD  = 3'd1;
    localparam logic [2:0] M_MULT = 3'd2;
    localparam logic [2:0] M_SUB  = 3'd3;
    localparam logic [2:0] M_MULQ = 3'd4;
    localparam logic [2:0] M_MAC  = 3'd5;
    localparam logic [2:0] M_CLR  = 3'd6;

    logic                     clk;
    logic                     rst;
    logic                     valid_i;
    logic                     ready_o;
    logic [2:0]               mode_i;
    logic signed [WIN-1:0]    op1_i;
    logic signed [WCOEF-1:0]  op2_i;
    logic                     valid_o;
    logic                     ready_i;
    logic signed [WOUT-1:0]   res_o;
    logic                     sat_o;

    int     checks    = 0;
    int     failures  = 0;
    int     out_count = 0;
    int     stall_seen = 0;
    longint last_res  = 0;
    longint last_sat  = 0;
    longint model_acc = 0;
    longint exp_res_q[$];
    longint exp_sat_q[$];

    ema_alu_pipe #(
        .WIN   (WIN),
        .WCOEF (WCOEF),
        .WOUT  (WOUT),
        .FRAC  (FRAC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .mode_i  (mode_i),
        .op1_i   (op1_i),
        .op2_i   (op2_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .res_o   (res_o),
        .sat_o   (sat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench never hangs
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Clip an integer into the signed WOUT range, reporting whether it clipped
    function automatic longint clip(input longint v, output longint s);
        longint max_v;
        longint min_v;
        max_v = (longint'(1) <<< (WOUT - 1)) - 1;
        min_v = -(longint'(1) <<< (WOUT - 1));
        s = 0;
        if (v > max_v) begin
            s = 1;
            return max_v;
        end
        if (v < min_v) begin
            s = 1;
            return min_v;
        end
        return v;
    endfunction

    // Reference model: result of one beat in plain arithmetic, in arrival order
    task automatic modelBeat(input logic [2:0] m, input longint a, input longint b);
        longint v;
        longint s;
        longint r;
        s = 0;
        case (m)
            M_ADD:  r = clip(a + b, s);
            M_MULT: r = clip(a * b, s);
            M_SUB:  r = clip(a - b, s);
            M_MULQ: begin
                v = a * b + (longint'(1) <<< (FRAC - 1));
                // floor division by 2^FRAC
                if (v >= 0) v = v / (longint'(1) <<< FRAC);
                else        v = -((-v + (longint'(1) <<< FRAC) - 1) / (longint'(1) <<< FRAC));
                r = clip(v, s);
            end
            M_MAC: begin
                model_acc = clip(model_acc + a * b, s);
                r = model_acc;
            end
            M_CLR: begin
                model_acc = 0;
                r = 0;
            end
            default: r = 0;
        endcase
        exp_res_q.push_back(r);
        exp_sat_q.push_back(s);
    endtask

    task automatic checkOutput(input string tag, input longint got, input longint expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, expected);
        end
    endtask

    // One clock cycle: drive on the falling edge, settle, then score transfers
    task automatic applyStimulus(input bit v, input logic [2:0] m, input int a,
                                 input int b, input bit rdy, output bit accepted);
        longint e;
        longint es;
        @(negedge clk);
        valid_i = v;
        mode_i  = m;
        op1_i   = a[WIN-1:0];
        op2_i   = b[WCOEF-1:0];
        ready_i = rdy;
        #1;
        accepted = 1'b0;
        if (!rst) begin
            if (valid_o && ready_i) begin
                if (exp_res_q.size() == 0) begin
                    checkOutput("unexpected_valid", 1, 0);
                end else begin
                    e  = exp_res_q.pop_front();
                    es = exp_sat_q.pop_front();
                    checkOutput("res", longint'(res_o), e);
                    checkOutput("sat", longint'(sat_o), es);
                    last_res = longint'(res_o);
                    last_sat = longint'(sat_o);
                    out_count++;
                end
            end
            if (valid_o && !ready_i) begin
                stall_seen++;
                checkOutput("stall_ready", longint'(ready_o), 0);
            end
            if (!valid_o) checkOutput("free_ready", longint'(ready_o), 1);
            if (valid_i && ready_o) begin
                accepted = 1'b1;
                modelBeat(m, longint'(a), longint'(b));
            end
        end
    endtask

    task automatic sendBeat(input logic [2:0] m, input int a, input int b);
        bit acc_ok;
        acc_ok = 1'b0;
        for (int i = 0; i < 50 && !acc_ok; i++) applyStimulus(1'b1, m, a, b, 1'b1, acc_ok);
        if (!acc_ok) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit dummy;
        for (int i = 0; i < 30 && (exp_res_q.size() != 0 || valid_o); i++)
            applyStimulus(1'b0, M_IDLE, 0, 0, 1'b1, dummy);
        checkOutput("drain_left", longint'(exp_res_q.size()), 0);
    endtask

    task automatic sendAndCheck(input string tag, input logic [2:0] m, input int a,
                                input int b, input longint er, input longint es);
        sendBeat(m, a, b);
        drain();
        checkOutput({tag, "_val"}, last_res, er);
        checkOutput({tag, "_sat"}, last_sat, es);
    endtask

    initial begin
        bit acc_ok;
        int k;
        int cyc;
        int base_count;
        int a;
        int b;
        logic [2:0] m;

        rst = 1'b1; valid_i = 1'b0; mode_i = M_IDLE; op1_i = '0; op2_i = '0; ready_i = 1'b1;
        repeat (3) applyStimulus(1'b0, M_IDLE, 0, 0, 1'b1, acc_ok);
        checkOutput("rst_valid", longint'(valid_o), 0);
        checkOutput("rst_res",   longint'(res_o), 0);
        checkOutput("rst_sat",   longint'(sat_o), 0);
        checkOutput("rst_ready", longint'(ready_o), 1);
        rst = 1'b0;

        $display("[TB] directed arithmetic");
        sendAndCheck("add",   M_ADD,  100, -30, 70, 0);
        sendAndCheck("sub",   M_SUB,  100, -30, 130, 0);
        sendAndCheck("mulq1", M_MULQ, 1000, 32768, 500, 0);
        sendAndCheck("mulq2", M_MULQ, 3, 32768, 2, 0);
        sendAndCheck("mulq3", M_MULQ, -3, 32768, -1, 0);
        sendAndCheck("mult_sat", M_MULT, -32768, -65536, 2147483647, 1);
        sendAndCheck("mult",  M_MULT, 2, 3, 6, 0);
        sendAndCheck("clr",   M_CLR,  0, 0, 0, 0);
        sendAndCheck("mac1",  M_MAC,  32767, 65535, 2147385345, 0);
        sendAndCheck("mac2",  M_MAC,  32767, 65535, 2147483647, 1);
        sendAndCheck("clr2",  M_CLR,  0, 0, 0, 0);
        sendAndCheck("mac3",  M_MAC,  1, 1, 1, 0);
        sendAndCheck("idle",  M_IDLE, 9, 9, 0, 0);
        sendAndCheck("rsvd",  3'd7,   9, 9, 0, 0);

        $display("[TB] backpressure stream");
        base_count = out_count;
        stall_seen = 0;
        k = 1;
        cyc = 0;
        while (k <= 5 && cyc < 40) begin
            applyStimulus(1'b1, M_ADD, k, 0, !(cyc >= 3 && cyc < 6), acc_ok);
            if (acc_ok) k++;
            cyc++;
        end
        drain();
        checkOutput("bp_count", longint'(out_count - base_count), 5);
        checkOutput("bp_last", last_res, 5);
        checkOutput("bp_stalled", longint'(stall_seen > 0), 1);
        sendAndCheck("mac_after_bp", M_MAC, 1, 1, 2, 0);

        $display("[TB] reset with beats in flight");
        sendBeat(M_MAC, 5, 5);
        sendBeat(M_MAC, 7, 7);
        rst = 1'b1;
        repeat (2) applyStimulus(1'b0, M_IDLE, 0, 0, 1'b1, acc_ok);
        exp_res_q.delete();
        exp_sat_q.delete();
        model_acc = 0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, M_IDLE, 0, 0, 1'b1, acc_ok);
            checkOutput("post_rst_valid", longint'(valid_o), 0);
        end
        sendAndCheck("mac_after_rst", M_MAC, 2, 2, 4, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       a = -32768;
                1:       a = 32767;
                default: a = int'($urandom_range(0, 65535)) - 32768;
            endcase
            case ($urandom_range(0, 3))
                0:       b = -65536;
                1:       b = 65535;
                default: b = int'($urandom_range(0, 131071)) - 65536;
            endcase
            m = 3'($urandom_range(0, 7));
            applyStimulus($urandom_range(0, 3) != 0, m, a, b, $urandom_range(0, 3) != 0, acc_ok);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
